// File: rtl/seq_detector_param.sv
// Programmable serial pattern detector: Mealy match flag, overlap/non-overlap modes, saturating match counter.
// Define SEQ_DET_MASK_EN to add a per-bit don't-care mask loaded alongside the pattern.
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data,
    input  logic             valid,
    input  logic [PAT_W-1:0] pattern,
    input  logic             pat_load,
    input  logic             overlap,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0] mask,
`endif
    output logic             detected,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int                FILL_W    = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PAT_W-1:0]  pat_reg;
    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  window;
    logic              hit;

`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0]  mask_reg;
`endif

    // The candidate window is the stored history with the current bit appended as the newest (LSB).
    always_comb begin
        window = {hist, data};
`ifdef SEQ_DET_MASK_EN
        hit = (((window ^ pat_reg) & mask_reg) == '0);
`else
        hit = (window == pat_reg);
`endif
        detected = valid & ~reset & ~pat_load & (fill == FILL_FULL) & hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_reg <= PAT_RST;
            hist    <= '0;
            fill    <= '0;
        end else if (pat_load) begin
            pat_reg <= pattern;
            hist    <= '0;
            fill    <= '0;
        end else if (valid) begin
            // A non-overlapping match consumes its bits, so the next match starts from an empty window.
            if (detected && !overlap) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= window[PAT_W-2:0];
                if (fill != FILL_FULL) begin
                    fill <= fill + FILL_W'(1);
                end
            end
        end
    end

`ifdef SEQ_DET_MASK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_reg <= '1;
        end else if (pat_load) begin
            mask_reg <= mask;
        end
    end
`endif

    // Counter stops at all-ones; the sticky flag rises on the same edge the counter reaches it.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_count <= '0;
            count_sat   <= 1'b0;
        end else if (detected && (match_count != CNT_MAX)) begin
            match_count <= match_count + CNT_W'(1);
            if ((match_count + CNT_W'(1)) == CNT_MAX) begin
                count_sat <= 1'b1;
            end
        end
    end

endmodule
